// File: rtl/pll_ctrl_pkg.sv
// Shared types and 27 MHz timing defaults for the PLL lock sequencer.
package pll_ctrl_pkg;

  typedef enum logic [2:0] {
    StRstPll,
    StWaitLock,
    StStable,
    StRun,
    StFail
  } state_e;

  localparam int unsigned DefRstCycles    = 32;
  localparam int unsigned DefLockTimeout  = 27000;  // 1 ms
  localparam int unsigned DefStableCycles = 2700;   // 100 us
  localparam int unsigned DefMaxRetry     = 3;
  localparam int unsigned DefCntW         = 16;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser with asynchronous active-low clear.
module sync_2ff #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_lock_ctrl.sv
// PLL power-up / lock supervision sequencer, clocked from the board reference only.
module pll_lock_ctrl
  import pll_ctrl_pkg::*;
#(
  parameter int unsigned RST_CYCLES    = DefRstCycles,
  parameter int unsigned LOCK_TIMEOUT  = DefLockTimeout,
  parameter int unsigned STABLE_CYCLES = DefStableCycles,
  parameter int unsigned MAX_RETRY     = DefMaxRetry,
  parameter int unsigned CNT_W         = DefCntW
) (
  input  logic       clkin,
  input  logic       reset_n,
  input  logic       pll_lock,
  input  logic       force_relock,
  output logic       pll_reset,
  output logic       sys_rst_n,
  output logic       locked,
  output logic       fail,
  output logic [1:0] retry_cnt
);

  localparam int unsigned MaxInterval = max3(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
  localparam logic [CNT_W-1:0] RstLast    = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] LockLast   = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] StableLast = CNT_W'(STABLE_CYCLES - 1);

  if ((MaxInterval >> CNT_W) != 0 || RST_CYCLES < 1 || RST_CYCLES > 255 ||
      LOCK_TIMEOUT < 1 || STABLE_CYCLES < 1 || MAX_RETRY > 3) begin : g_bad_params
    $error("pll_lock_ctrl: timing parameters out of range for CNT_W");
  end

  logic             lock_s;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       retry_d, retry_inc;

  sync_2ff #(
    .WIDTH(1)
  ) u_lock_sync (
    .clk  (clkin),
    .rst_n(reset_n),
    .d    (pll_lock),
    .q    (lock_s)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 1'b1;
    retry_d   = retry_cnt;
    retry_inc = (retry_cnt == 2'd3) ? 2'd3 : retry_cnt + 2'd1;

    unique case (state_q)
      StRstPll: begin
        if (cnt_q == RstLast) begin
          state_d = StWaitLock;
          cnt_d   = '0;
        end
      end
      StWaitLock: begin
        if (lock_s) begin
          state_d = StStable;
          cnt_d   = '0;
        end else if (cnt_q == LockLast) begin
          retry_d = retry_inc;
          state_d = (MAX_RETRY != 0 && 32'(retry_inc) == MAX_RETRY) ? StFail : StRstPll;
          cnt_d   = '0;
        end
      end
      StStable: begin
        // Loss outranks terminal count: a drop on the last cycle still retries.
        if (!lock_s) begin
          retry_d = retry_inc;
          state_d = (MAX_RETRY != 0 && 32'(retry_inc) == MAX_RETRY) ? StFail : StRstPll;
          cnt_d   = '0;
        end else if (cnt_q == StableLast) begin
          state_d = StRun;
          cnt_d   = '0;
        end
      end
      StRun: begin
        cnt_d = '0;
        if (!lock_s) begin
          state_d = StRstPll;
          retry_d = 2'd0;
        end
      end
      StFail: begin
        cnt_d = '0;
        if (force_relock) begin
          state_d = StRstPll;
          retry_d = 2'd0;
        end
      end
      default: begin
        state_d = StRstPll;
        cnt_d   = '0;
      end
    endcase

    if (force_relock && state_q != StFail) begin
      state_d = StRstPll;
      cnt_d   = '0;
      retry_d = 2'd0;
    end
  end

  // Outputs are registered from the next state so they change with the state itself.
  always_ff @(posedge clkin or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StRstPll;
      cnt_q     <= '0;
      retry_cnt <= 2'd0;
      pll_reset <= 1'b1;
      sys_rst_n <= 1'b0;
      locked    <= 1'b0;
      fail      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      retry_cnt <= retry_d;
      pll_reset <= (state_d == StRstPll) || (state_d == StFail);
      sys_rst_n <= (state_d == StRun);
      locked    <= (state_d == StRun);
      fail      <= (state_d == StFail);
    end
  end

endmodule
